// File: rtl/alu_instr_encoder.sv
// ALU op/field -> 16-bit instruction encoder with a DEPTH-entry output FIFO and valid/ready handshakes.
// Optional ENC_BYPASS_EN: zero-latency pass-through when the FIFO is empty and downstream is ready.
module alu_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [11:0] in_field,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  input  logic        err_clr,
  output logic        err_illegal
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   enc_word;
  logic          legal, accept, push, pop, fifo_vld, byp;

  always_comb begin
    enc_word = 16'h0000;
    legal    = 1'b1;
    case (in_op)
      5'd0:  enc_word = {4'b0000, in_field};
      5'd1:  enc_word = {4'b0001, in_field};
      5'd2:  enc_word = {4'b0010, in_field};
      5'd3:  enc_word = {4'b0100, in_field};
      5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11:
        enc_word = {4'b1000, in_field[11:8], 8'd1 << (in_op - 5'd4)};
      // ops 12..14 map to 8'h81..8'h83
      5'd12, 5'd13, 5'd14:
        enc_word = {4'b1000, in_field[11:8], 6'b100000, in_op[1:0] + 2'd1};
      5'd15: enc_word = {4'b1100, in_field};
      5'd16: enc_word = {4'b1101, in_field};
      5'd17: enc_word = {4'b1110, in_field};
      5'd18: enc_word = {4'b1111, in_field};
      default: legal = 1'b0;
    endcase
  end

  assign fifo_vld = (count != '0);
  assign in_ready = (count != FULL);
  assign accept   = in_valid && in_ready;

`ifdef ENC_BYPASS_EN
  assign byp = !fifo_vld && in_valid && legal && out_ready;
`else
  assign byp = 1'b0;
`endif

  assign push      = accept && legal && !byp;
  assign pop       = fifo_vld && out_ready;
  assign out_valid = fifo_vld || byp;
  assign out_instr = byp ? enc_word : (fifo_vld ? mem[rd_ptr] : 16'h0000);

  // Storage carries no reset; count gates visibility of stale entries.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= enc_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (err_clr)               err_illegal <= 1'b0;
      else if (accept && !legal) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed scenarios plus random traffic against a queue model.
module tb_alu_instr_encoder;

`ifdef ENC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic [4:0]  in_op = '0;
  logic [11:0] in_field = '0;
  logic        in_ready, out_valid, err_illegal;
  logic [15:0] out_instr;

  int n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  bit merr = 1'b0;

  localparam int PRE [19] = '{0,1,2,4,8,8,8,8,8,8,8,8,8,8,8,12,13,14,15};

  alu_instr_encoder #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_field(in_field), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr),
    .err_clr(err_clr), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_enc(int op, logic [11:0] f);
    int lo;
    if (op >= 4 && op <= 14) begin
      lo = (op <= 11) ? (1 << (op - 4)) : (128 + op - 11);
      return {4'(PRE[op]), f[11:8], 8'(lo)};
    end
    return {4'(PRE[op]), f};
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs at negedge against the model, advance model at posedge.
  task automatic cyc(bit v, int op, logic [11:0] f, bit ordy, bit clr);
    bit lg, bp, acc, pp;
    in_valid = v; in_op = 5'(op); in_field = f; out_ready = ordy; err_clr = clr;
    lg = (op <= 18);
    @(negedge clk);
    bp = BYP && q.size() == 0 && v && lg && ordy;
    chk("in_ready",  16'(in_ready),    16'(q.size() != 4));
    chk("out_valid", 16'(out_valid),   16'(bp || q.size() != 0));
    chk("out_instr", out_instr,        bp ? ref_enc(op, f) : (q.size() != 0 ? q[0] : 16'h0));
    chk("err",       16'(err_illegal), 16'(merr));
    @(posedge clk);
    acc = v && q.size() != 4;
    pp  = q.size() != 0 && ordy;
    if (pp) void'(q.pop_front());
    if (acc && lg && !bp) q.push_back(ref_enc(op, f));
    if (clr) merr = 1'b0;
    else if (acc && !lg) merr = 1'b1;
    #1;
  endtask

  task automatic lit(int op, logic [15:0] exp);
    cyc(1, op, 12'hA5C, 0, 0);
    chk($sformatf("enc_op%0d", op), out_instr, exp);
    cyc(0, 0, 12'h0, 1, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ov", 16'(out_valid), 16'h0);
    chk("rst_oi", out_instr, 16'h0);
    chk("rst_err", 16'(err_illegal), 16'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ir", 16'(in_ready), 16'h1);

    // encode sweep
    for (int op = 0; op < 19; op++) cyc(1, op, 12'hA5C, 1, 0);
    cyc(0, 0, 12'h0, 1, 0);
    lit(0, 16'h0A5C);
    lit(7, 16'h8A08);
    lit(14, 16'h8A83);
    lit(18, 16'hFA5C);

    // full: no pop-through
    for (int i = 0; i < 4; i++) cyc(1, i + 15, 12'h100 + 12'(i), 0, 0);
    chk("full_ir", 16'(in_ready), 16'h0);
    cyc(1, 3, 12'h777, 0, 0);
    cyc(1, 3, 12'h777, 1, 0);
    cyc(1, 3, 12'h777, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 12'h0, 1, 0);

    // simultaneous push/pop across pointer wrap
    cyc(1, 2, 12'h001, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, i + 4, 12'h0F0 + 12'(i), 1, 0);
    chk("wrap_cnt1", 16'(q.size()), 16'd1);
    cyc(0, 0, 12'h0, 1, 0);
    cyc(0, 0, 12'h0, 1, 0);

    // illegal op, then clear racing a second illegal
    cyc(1, 25, 12'hFFF, 1, 0);
    chk("ill_set", 16'(err_illegal), 16'h1);
    chk("ill_nowd", 16'(out_valid), 16'h0);
    cyc(1, 25, 12'hFFF, 1, 1);
    chk("ill_clr", 16'(err_illegal), 16'h0);
    cyc(0, 0, 12'h0, 1, 0);

    // bypass / minimum latency
    if (BYP) begin
      in_valid = 1; in_op = 5'd1; in_field = 12'h123; out_ready = 1; err_clr = 0;
      #1;
      chk("byp_same", out_instr, 16'h1123);
      cyc(1, 1, 12'h123, 1, 0);
    end else begin
      cyc(1, 1, 12'h123, 1, 0);
      chk("byp_next", out_instr, 16'h1123);
    end
    cyc(0, 0, 12'h0, 1, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 3) != 0, ($urandom_range(0, 7) == 0) ? int'($urandom_range(19, 31)) : int'($urandom_range(0, 18)),
          12'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

    // reset mid-burst with 3 words queued and the error flag set
    while (q.size() != 0) cyc(0, 0, 12'h0, 1, 0);
    cyc(1, 30, 12'h0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, i, 12'hABC, 0, 0);
    chk("pre_rst_ov", 16'(out_valid), 16'h1);
    in_valid = 0; out_ready = 0;
    rst = 1'b0;
    #1;
    chk("mrst_ov", 16'(out_valid), 16'h0);
    chk("mrst_oi", out_instr, 16'h0);
    chk("mrst_err", 16'(err_illegal), 16'h0);
    q.delete(); merr = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ir", 16'(in_ready), 16'h1);
    cyc(1, 16, 12'h5A5, 1, 0);
    cyc(0, 0, 12'h0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
